// File: rtl/dp_arbiter_pkg.sv
// rtl/dp_arbiter_pkg.sv - shared widths and arbiter state encoding for dp_arbiter
package dp_arbiter_pkg;

    localparam int INSTRUCTION_WIDTH = 16;
    localparam int RESULT_WIDTH      = 8;
    localparam int ARB_ST_WIDTH      = 2;

    typedef enum logic [ARB_ST_WIDTH-1:0] {
        ARB_ST_IDLE  = 2'd0,
        ARB_ST_ISSUE = 2'd1,
        ARB_ST_HOLD  = 2'd2,
        ARB_ST_WAIT  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/dp_arbiter_if.sv
// rtl/dp_arbiter_if.sv - requester-side and datapath-side handshake bundle for dp_arbiter
interface dp_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
);
    import dp_arbiter_pkg::*;

    logic [NUM_REQ-1:0]                   req_start;
    logic [NUM_REQ*INSTRUCTION_WIDTH-1:0] req_instruction;
    logic [NUM_REQ-1:0]                   req_finished;
    logic [NUM_REQ*RESULT_WIDTH-1:0]      req_result;

    logic                                 start_dp;
    logic [INSTRUCTION_WIDTH-1:0]         instruction_dp;
    logic                                 finished_dp;
    logic [RESULT_WIDTH-1:0]              result_dp;

    logic                                 busy;
    logic [IDX_W-1:0]                     grant;

    // The arbiter itself uses the slave view; sequencers plus datapath use master.
    modport slave (
        input  req_start, req_instruction, finished_dp, result_dp,
        output req_finished, req_result, start_dp, instruction_dp, busy, grant
    );

    modport master (
        output req_start, req_instruction, finished_dp, result_dp,
        input  req_finished, req_result, start_dp, instruction_dp, busy, grant
    );

endinterface

// File: rtl/dp_arbiter_rr_pick.sv
// rtl/dp_arbiter_rr_pick.sv - combinational round-robin priority encoder starting after last
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    assign valid = |pending;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        int                j;
        logic [IDX_W-1:0]  cand;
        idx  = '0;
        j    = 0;
        cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = int'(last) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            cand = IDX_W'(j);
            if (pending[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/dp_arbiter.sv
// rtl/dp_arbiter.sv - round-robin sharing of one datapath start/finished port among NUM_REQ sequencers
module dp_arbiter
    import dp_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic        clock,
    input  logic        resetn,
    dp_arbiter_if.slave bus
);

    arb_state_t                       state;
    arb_state_t                       state_nxt;

    logic [NUM_REQ-1:0]               pending;
    logic [INSTRUCTION_WIDTH-1:0]     instr_latch [NUM_REQ];
    logic [NUM_REQ-1:0]               fin_q;
    logic [NUM_REQ*RESULT_WIDTH-1:0]  res_q;

    logic [IDX_W-1:0]                 grant_q;
    logic [IDX_W-1:0]                 last_q;
    logic                             start_dp_q;
    logic [INSTRUCTION_WIDTH-1:0]     instr_dp_q;

    logic                             pick_valid;
    logic [IDX_W-1:0]                 pick_idx;

    logic                             do_grant;
    logic                             do_issue;
    logic                             do_complete;
    logic                             start_nxt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .pending (pending),
        .last    (last_q),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ARB_ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_ST_IDLE:  if (pick_valid) state_nxt = ARB_ST_ISSUE;
            ARB_ST_ISSUE: state_nxt = ARB_ST_HOLD;
            ARB_ST_HOLD:  state_nxt = ARB_ST_WAIT;
            ARB_ST_WAIT:  if (bus.finished_dp) state_nxt = ARB_ST_IDLE;
            default:      state_nxt = ARB_ST_IDLE;
        endcase
    end

    always_comb begin
        do_grant    = 1'b0;
        do_issue    = 1'b0;
        do_complete = 1'b0;
        start_nxt   = 1'b0;
        case (state)
            ARB_ST_IDLE:  do_grant = pick_valid;
            ARB_ST_ISSUE: begin
                do_issue  = 1'b1;
                start_nxt = 1'b1;
            end
            ARB_ST_HOLD:  start_nxt = 1'b1;
            ARB_ST_WAIT:  do_complete = bus.finished_dp;
            default:      start_nxt = 1'b0;
        endcase
    end

    // Datapath-facing registers; start_dp spans ISSUE->HOLD and HOLD->WAIT, i.e. two cycles.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            start_dp_q <= 1'b0;
            instr_dp_q <= '0;
            grant_q    <= '0;
            last_q     <= IDX_W'(NUM_REQ - 1);
        end else begin
            start_dp_q <= start_nxt;
            if (do_grant) begin
                grant_q <= pick_idx;
            end
            if (do_issue) begin
                instr_dp_q <= instr_latch[grant_q];
            end
            if (do_complete) begin
                last_q <= grant_q;
            end
        end
    end

    // Completion is written after capture so it wins if both hit the same requester.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pending <= '0;
            fin_q   <= '1;
            res_q   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                instr_latch[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_start[i] && !pending[i]) begin
                    pending[i]     <= 1'b1;
                    instr_latch[i] <= bus.req_instruction[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
                    fin_q[i]       <= 1'b0;
                end
            end
            if (do_complete) begin
                pending[grant_q] <= 1'b0;
                fin_q[grant_q]   <= 1'b1;
                res_q[grant_q*RESULT_WIDTH +: RESULT_WIDTH] <= bus.result_dp;
            end
        end
    end

    assign bus.start_dp       = start_dp_q;
    assign bus.instruction_dp = instr_dp_q;
    assign bus.req_finished   = fin_q;
    assign bus.req_result     = res_q;
    assign bus.grant          = grant_q;
    assign bus.busy           = (state != ARB_ST_IDLE);

endmodule

// File: tb/tb_dp_arbiter.sv
// tb/tb_dp_arbiter.sv - self-checking bench for dp_arbiter with a cycle-level behavioural model
module tb_dp_arbiter;

    logic clock;
    logic resetn;

    int errors;
    int checks;

    dp_arbiter_if #(.NUM_REQ(4), .IDX_W(2)) bus ();

    dp_arbiter #(.NUM_REQ(4), .IDX_W(2)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Datapath stand-in: drops finished on start, raises it dp_delay cycles later.
    int dp_delay;
    int dp_cnt;
    initial begin
        bus.finished_dp = 1'b1;
        bus.result_dp   = '0;
        dp_cnt          = 0;
        forever begin
            @(negedge clock);
            if (bus.start_dp) begin
                bus.finished_dp = 1'b0;
                dp_cnt          = 0;
            end else if (!bus.finished_dp) begin
                dp_cnt++;
                if (dp_cnt >= dp_delay) begin
                    bus.finished_dp = 1'b1;
                    bus.result_dp   = bus.instruction_dp[7:0] + 8'h96;
                end
            end
        end
    end

    // Behavioural model: age counts edges since the grant (-1 when idle).
    int          m_age;
    int          m_grant;
    int          m_last;
    logic [3:0]  m_pend;
    logic [3:0]  m_fin;
    logic [15:0] m_instr [4];
    logic [7:0]  m_res [4];
    logic [15:0] m_idp;

    int glog[$];
    int runs[$];
    int hi_run;

    function automatic int rr_next(input logic [3:0] p, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (p[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] old_pend;
        old_pend = m_pend;
        if (!resetn) begin
            m_age = -1; m_grant = 0; m_last = 3; m_pend = '0; m_fin = 4'hF; m_idp = '0;
            for (int i = 0; i < 4; i++) begin
                m_instr[i] = '0;
                m_res[i]   = '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_start[i] && !old_pend[i]) begin
                    m_pend[i]  = 1'b1;
                    m_instr[i] = bus.req_instruction[i*16 +: 16];
                    m_fin[i]   = 1'b0;
                end
            end
            if (m_age < 0) begin
                if (old_pend != 4'b0) begin
                    m_grant = rr_next(old_pend, m_last);
                    m_age   = 0;
                end
            end else if (m_age == 0) begin
                m_idp = m_instr[m_grant];
                m_age = 1;
            end else if (m_age >= 2 && bus.finished_dp) begin
                m_res[m_grant]  = bus.result_dp;
                m_fin[m_grant]  = 1'b1;
                m_pend[m_grant] = 1'b0;
                m_last          = m_grant;
                m_age           = -1;
            end else if (m_age < 3) begin
                m_age++;
            end
        end
    endtask

    task automatic compare_cycle();
        logic [31:0] exp_res;
        exp_res = '0;
        for (int i = 0; i < 4; i++) exp_res[i*8 +: 8] = m_res[i];
        chk("start_dp",       32'(bus.start_dp),       32'(m_age == 1 || m_age == 2));
        chk("busy",           32'(bus.busy),           32'(m_age >= 0));
        chk("grant",          32'(bus.grant),          32'(m_grant[1:0]));
        chk("instruction_dp", 32'(bus.instruction_dp), 32'(m_idp));
        chk("req_finished",   32'(bus.req_finished),   32'(m_fin));
        chk("req_result",     bus.req_result,          exp_res);
        if (bus.start_dp) begin
            if (hi_run == 0) glog.push_back(int'(bus.grant));
            hi_run++;
        end else if (hi_run > 0) begin
            runs.push_back(hi_run);
            hi_run = 0;
        end
    endtask

    task automatic req_go(input int i, input logic [15:0] ins);
        @(negedge clock);
        bus.req_instruction[i*16 +: 16] = ins;
        bus.req_start[i] = 1'b1;
        @(negedge clock);
        @(negedge clock);
        bus.req_start[i] = 1'b0;
    endtask

    task automatic wait_fin(input int i, input int budget, output logic [3:0] and_fin);
        bit saw_low;
        int n;
        saw_low = 1'b0;
        and_fin = 4'hF;
        n = 0;
        while (n < budget) begin
            @(negedge clock);
            and_fin = and_fin & bus.req_finished;
            if (!bus.req_finished[i]) saw_low = 1'b1;
            else if (saw_low) break;
            n++;
        end
        if (n >= budget) chk($sformatf("timeout_fin%0d", i), 32'(n), 32'(budget - 1));
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        logic [3:0] af;
        logic [3:0] af2;
        int base;
        int bad;
        int k;
        errors = 0; checks = 0; hi_run = 0;
        dp_delay = 3;
        resetn = 1'b0;
        bus.req_start = '0;
        bus.req_instruction = '0;
        m_pend = '0; m_age = -1;
        fork
            forever begin
                @(posedge clock);
                model_step();
                #2;
                compare_cycle();
            end
        join_none

        // Reset then idle
        @(negedge clock);
        chk("rst_finished", 32'(bus.req_finished), 32'hF);
        chk("rst_start_dp", 32'(bus.start_dp), 32'h0);
        chk("rst_busy",     32'(bus.busy), 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle_busy", 32'(bus.busy), 32'h0);

        // Single request from requester 2
        base = glog.size();
        req_go(2, 16'h0015);
        wait_fin(2, 60, af);
        chk("single_result2", 32'(bus.req_result[23:16]), 32'hAB);
        chk("single_instr",   32'(bus.instruction_dp), 32'h15);
        chk("single_grant",   32'(glog[base]), 32'd2);
        chk("single_run",     32'(runs[runs.size()-1]), 32'd2);
        chk("single_others",  32'(af), 32'b1011);

        // Simultaneous requests 0, 1, 3 after reset so requester 0 leads
        pulse_reset();
        base = glog.size();
        fork
            req_go(0, 16'h0101);
            req_go(1, 16'h0202);
            req_go(3, 16'h0303);
        join
        wait_fin(0, 60, af);
        wait_fin(1, 60, af);
        wait_fin(3, 60, af);
        chk("order0", 32'(glog[base]),   32'd0);
        chk("order1", 32'(glog[base+1]), 32'd1);
        chk("order2", 32'(glog[base+2]), 32'd3);
        chk("route",  bus.req_result, 32'h9900_9897);

        // Fairness: 0 and 1 re-request immediately, 10 transactions
        base = glog.size();
        fork
            for (int t = 0; t < 5; t++) begin
                req_go(0, 16'h0040 + 16'(t));
                wait_fin(0, 60, af);
            end
            for (int t = 0; t < 5; t++) begin
                req_go(1, 16'h0050 + 16'(t));
                wait_fin(1, 60, af2);
            end
        join
        chk("fair_count", 32'(glog.size() - base), 32'd10);
        for (k = 0; k < 10 && base + k < glog.size(); k++) begin
            chk($sformatf("fair_grant%0d", k), 32'(glog[base+k]), 32'(k % 2));
        end

        // Datapath stall with a request from 3 queued behind requester 0
        dp_delay = 50;
        base = glog.size();
        req_go(0, 16'h0010);
        req_go(3, 16'h0033);
        bad = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.start_dp || bus.grant != 2'd0 || !bus.busy) bad++;
        end
        chk("stall_quiet", 32'(bad), 32'd0);
        wait_fin(0, 100, af);
        dp_delay = 3;
        wait_fin(3, 60, af);
        chk("stall_grant0", 32'(glog[base]),   32'd0);
        chk("stall_grant3", 32'(glog[base+1]), 32'd3);
        chk("stall_res0",   32'(bus.req_result[7:0]),   32'hA6);
        chk("stall_res3",   32'(bus.req_result[31:24]), 32'hC9);

        // Reset while in HOLD
        req_go(1, 16'h0077);
        k = 0;
        while (!bus.start_dp && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("hold_reached", 32'(bus.start_dp), 32'h1);
        #1 resetn = 1'b0;
        #1;
        chk("mid_start_dp", 32'(bus.start_dp), 32'h0);
        chk("mid_finished", 32'(bus.req_finished), 32'hF);
        chk("mid_busy",     32'(bus.busy), 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.busy) bad++;
        end
        chk("mid_pending_cleared", 32'(bad), 32'd0);
        req_go(1, 16'h0042);
        wait_fin(1, 60, af);
        chk("post_reset_res1", 32'(bus.req_result[15:8]), 32'hD8);

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
